// File: rtl/qam_demapper_packer.sv
// qam_demapper_packer: hard-decision Gray demapper for QPSK/16-QAM/64-QAM packing bits MSB-first into OW-bit words
module qam_demapper_packer #(
  parameter int IW = 16,
  parameter int SCH = 2,
  parameter int STEP = 2,
  parameter int OW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2*IW-1:0] din,
  input  logic            din_valid,
  output logic            din_ready,
  input  logic [1:0]      mode,
  input  logic            flush,
  output logic [OW-1:0]   dout,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic            dout_last,
  output logic            mode_err
);
  localparam int TW = IW - SCH;
  localparam int AW = OW + 5;
  localparam int CW = $clog2(OW + 6);
  localparam logic [CW-1:0] OWC = CW'(OW);
  typedef enum logic [1:0] {RUN, DRAIN, EMIT} state_t;
  state_t st, st_n;
  logic up, s_v, hs, absorb, take;
  logic [5:0] s_b, sym;
  logic [2:0] s_n, nb, kr, ki, xr, xi, lm;
  logic [AW-1:0] acc, acc_ps;
  logic [CW-1:0] cnt, cnt_ps;
  int l;
  function automatic logic [2:0] region(input logic signed [TW-1:0] v, input int lv);
    int k, vi;
    k = 0;
    vi = int'(v);
    for (int j = 1; j < 8; j++) if (j < lv && vi >= (j - lv / 2) * STEP) k++;
    return k[2:0];
  endfunction
  always_comb begin
    l = mode == 2'd0 ? 2 : mode == 2'd1 ? 4 : 8;
    lm = 3'(l - 1);
    kr = region(din[IW-1:SCH], l);
    ki = lm - region(din[2*IW-1:IW+SCH], l);
    xr = kr ^ (kr >> 1);
    xi = ki ^ (ki >> 1);
    sym = mode == 2'd0 ? {xr[0], xi[0], 4'b0} : mode == 2'd1 ? {xr[1:0], xi[1:0], 2'b0} : {xr, xi};
    nb = mode == 2'd0 ? 3'd2 : mode == 2'd1 ? 3'd4 : 3'd6;
  end
  assign dout_valid = cnt >= OWC || st == EMIT;
  assign dout_last = st == EMIT;
  assign dout = acc[AW-1 -: OW];
  // absorb decision sees the count after any same-cycle word shift-out
  always_comb begin
    hs = dout_valid & dout_ready;
    cnt_ps = !hs ? cnt : st == EMIT ? '0 : cnt - OWC;
    acc_ps = !hs ? acc : st == EMIT ? '0 : acc << OW;
    absorb = s_v && cnt_ps < OWC;
    din_ready = up && st == RUN && (!s_v || absorb);
    take = din_valid && din_ready;
  end
  always_comb begin
    st_n = st;
    if (st == RUN) st_n = flush ? DRAIN : RUN;
    else if (st == DRAIN) st_n = (!s_v && cnt < OWC) ? (cnt == '0 ? RUN : EMIT) : DRAIN;
    else st_n = hs ? RUN : EMIT;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= RUN;
      up <= 1'b0;
      s_v <= 1'b0;
      s_b <= '0;
      s_n <= '0;
      acc <= '0;
      cnt <= '0;
      mode_err <= 1'b0;
    end else begin
      st <= st_n;
      up <= 1'b1;
      acc <= absorb ? acc_ps | ({s_b, {(AW-6){1'b0}}} >> cnt_ps) : acc_ps;
      cnt <= absorb ? cnt_ps + CW'(s_n) : cnt_ps;
      if (take && mode != 2'd3) begin
        s_v <= 1'b1;
        s_b <= sym;
        s_n <= nb;
      end else if (absorb) s_v <= 1'b0;
      if (take && mode == 2'd3) mode_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_qam_demapper_packer.sv
// tb_qam_demapper_packer: vector table, directed corner sequences and randomized traffic against a bit-queue model
module tb_qam_demapper_packer;
  localparam int IW = 16, SCH = 2, STEP = 2, OW = 8;
  logic clk = 0, rst_n = 0;
  logic [2*IW-1:0] din = '0;
  logic din_valid = 0, din_ready, flush = 0, dout_valid, dout_ready = 1, dout_last, mode_err;
  logic [1:0] mode = '0;
  logic [OW-1:0] dout;
  int n_chk = 0, n_fail = 0, nwords = 0;
  typedef struct {logic [OW-1:0] w; logic last;} word_t;
  typedef struct {logic [1:0] m; int re; int im; logic [7:0] w;} vec_t;
  bit bitq[$];
  word_t expq[$];
  logic [OW-1:0] got[$];
  logic me = 0, in_flush = 0, took = 0;
  vec_t tbl[12];

  always #5 clk = ~clk;

  qam_demapper_packer #(.IW(IW), .SCH(SCH), .STEP(STEP), .OW(OW)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .mode(mode), .flush(flush), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .mode_err(mode_err));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // region index straight from the boundary rule: floor(v/STEP) + L/2, clamped
  function automatic int axis_k(input int raw, input int lv);
    int v, f;
    v = raw >>> SCH;
    f = (v >= 0) ? v / STEP : -((-v + STEP - 1) / STEP);
    f = f + lv / 2;
    return f < 0 ? 0 : f > lv - 1 ? lv - 1 : f;
  endfunction

  function automatic void push_sym(input int m, input int re, input int im);
    int lv, b, gr, gi, kr, ki;
    logic [OW-1:0] w;
    lv = 2 << m;
    b = m + 1;
    kr = axis_k(re, lv);
    ki = lv - 1 - axis_k(im, lv);
    gr = kr ^ (kr >> 1);
    gi = ki ^ (ki >> 1);
    for (int i = b - 1; i >= 0; i--) bitq.push_back(gr[i]);
    for (int i = b - 1; i >= 0; i--) bitq.push_back(gi[i]);
    while (bitq.size() >= OW) begin
      w = '0;
      for (int i = 0; i < OW; i++) w = {w[OW-2:0], bitq.pop_front()};
      expq.push_back('{w, 1'b0});
    end
  endfunction

  function automatic void pad_flush();
    logic [OW-1:0] w;
    if (bitq.size() == 0) return;
    w = '0;
    for (int i = 0; i < OW; i++) w = {w[OW-2:0], (i < bitq.size()) ? bitq[i] : 1'b0};
    expq.push_back('{w, 1'b1});
    bitq.delete();
  endfunction

  task automatic monitor();
    word_t e;
    took = 0;
    if (!rst_n) return;
    if (dout_valid) begin
      if (expq.size() == 0) chk("dout_valid_unexpected", 32'(dout_valid), 32'(0));
      else begin
        e = expq[0];
        chk("dout", 32'(dout), 32'(e.w));
        chk("dout_last", 32'(dout_last), 32'(e.last));
        if (dout_ready) begin
          void'(expq.pop_front());
          got.push_back(dout);
          nwords++;
        end
      end
    end
    chk("mode_err", 32'(mode_err), 32'(me));
    if (din_valid && din_ready) begin
      took = 1;
      if (mode == 2'd3) me = 1;
      else push_sym(int'(mode), $signed(din[IW-1:0]), $signed(din[2*IW-1:IW]));
    end
    if (flush && !in_flush) begin
      pad_flush();
      in_flush = 1;
    end else if (in_flush && din_ready) in_flush = 0;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] m, input int re, input int im);
    mode = m;
    din = {IW'(im), IW'(re)};
    din_valid = 1;
    for (int t = 0; t < 50; t++) begin
      step();
      if (took) break;
    end
    chk("symbol_accepted", 32'(took), 32'(1));
    din_valid = 0;
  endtask

  task automatic flush_pulse();
    flush = 1;
    step();
    flush = 0;
  endtask

  task automatic wait_word();
    for (int t = 0; t < 30 && !dout_valid; t++) step();
    chk("dout_valid_arrives", 32'(dout_valid), 32'(1));
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 60 && !(din_ready && !in_flush); t++) step();
    chk("idle_reached", 32'(din_ready && !in_flush), 32'(1));
  endtask

  initial begin
    int idx;
    tbl[0] = '{2'd0, 4, 4, 8'h80};
    tbl[1] = '{2'd0, -4, -4, 8'h40};
    tbl[2] = '{2'd0, 3, -1, 8'hC0};
    tbl[3] = '{2'd1, -12, 12, 8'h00};
    tbl[4] = '{2'd1, 4, -4, 8'hF0};
    tbl[5] = '{2'd1, -8, 8, 8'h40};
    tbl[6] = '{2'd1, -9, 7, 8'h10};
    tbl[7] = '{2'd2, 28, -28, 8'h90};
    tbl[8] = '{2'd2, 0, -4, 8'hD8};
    tbl[9] = '{2'd2, -32768, -32768, 8'h10};
    tbl[10] = '{2'd2, -24, 20, 8'h24};
    tbl[11] = '{2'd2, 8, -9, 8'hFC};
    step();
    step();
    rst_n = 1;
    chk("rst_din_ready", 32'(din_ready), 32'(0));
    chk("rst_dout_valid", 32'(dout_valid), 32'(0));
    chk("rst_dout", 32'(dout), 32'(0));
    chk("rst_dout_last", 32'(dout_last), 32'(0));
    chk("rst_mode_err", 32'(mode_err), 32'(0));
    step();
    chk("din_ready_after_reset", 32'(din_ready), 32'(1));

    foreach (tbl[i]) begin
      send(tbl[i].m, tbl[i].re, tbl[i].im);
      flush_pulse();
      wait_word();
      chk($sformatf("tbl%0d_word", i), 32'(dout), 32'(tbl[i].w));
      chk($sformatf("tbl%0d_last", i), 32'(dout_last), 32'(1));
      wait_idle();
    end

    // 16-QAM pair into one word, with latency check under a stalled sink
    dout_ready = 0;
    send(2'd1, -12, 12);
    send(2'd1, 4, -4);
    chk("lat_not_yet", 32'(dout_valid), 32'(0));
    step();
    chk("lat_valid", 32'(dout_valid), 32'(1));
    chk("lat_word", 32'(dout), 32'(8'h0F));
    chk("lat_last", 32'(dout_last), 32'(0));
    dout_ready = 1;
    step();
    chk("lat_consumed", 32'(dout_valid), 32'(0));

    // 64-QAM at full rate, then flush with nothing pending
    got.delete();
    mode = 2'd2;
    din = {IW'(-28), IW'(28)};
    din_valid = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("qam64_rate", 32'(took), 32'(1));
    end
    din_valid = 0;
    repeat (4) step();
    chk("qam64_count", 32'(got.size()), 32'(3));
    if (got.size() == 3) begin
      chk("qam64_w0", 32'(got[0]), 32'(8'h92));
      chk("qam64_w1", 32'(got[1]), 32'(8'h49));
      chk("qam64_w2", 32'(got[2]), 32'(8'h24));
    end
    flush_pulse();
    wait_idle();
    chk("empty_flush_no_word", 32'(got.size()), 32'(3));

    // backpressure: intake stops once a full word and a full stage are held
    got.delete();
    dout_ready = 0;
    mode = 2'd1;
    din_valid = 1;
    idx = 0;
    for (int t = 0; t < 8; t++) begin
      din = idx % 2 ? {IW'(-4), IW'(4)} : {IW'(12), IW'(-12)};
      step();
      if (took) idx++;
    end
    chk("bp_accepted", 32'(idx), 32'(3));
    chk("bp_din_ready", 32'(din_ready), 32'(0));
    chk("bp_dout_held", 32'(dout), 32'(8'h0F));
    dout_ready = 1;
    for (int t = 0; t < 40 && idx < 8; t++) begin
      din = idx % 2 ? {IW'(-4), IW'(4)} : {IW'(12), IW'(-12)};
      step();
      if (took) idx++;
    end
    din_valid = 0;
    repeat (4) step();
    chk("bp_words", 32'(got.size()), 32'(4));
    foreach (got[i]) chk($sformatf("bp_w%0d", i), 32'(got[i]), 32'(8'h0F));

    // mixed orders across a word, plus a reserved-mode symbol
    got.delete();
    send(2'd0, 4, 4);
    send(2'd2, 28, -28);
    send(2'd3, 100, 100);
    repeat (3) step();
    chk("mixed_count", 32'(got.size()), 32'(1));
    if (got.size() > 0) chk("mixed_word", 32'(got[0]), 32'(8'hA4));
    chk("mixed_mode_err", 32'(mode_err), 32'(1));
    flush_pulse();
    wait_idle();
    chk("mixed_no_extra", 32'(got.size()), 32'(1));

    // reset while a flush word is stalled
    dout_ready = 0;
    send(2'd0, 4, 4);
    flush_pulse();
    for (int t = 0; t < 10 && !dout_last; t++) step();
    chk("emit_reached", 32'(dout_last), 32'(1));
    rst_n = 0;
    step();
    rst_n = 1;
    bitq.delete();
    expq.delete();
    me = 0;
    in_flush = 0;
    chk("mid_rst_outputs", 32'({dout, dout_valid, dout_last, mode_err, din_ready}), 32'(0));
    dout_ready = 1;
    step();
    chk("mid_rst_ready", 32'(din_ready), 32'(1));
    send(2'd1, 4, -4);
    flush_pulse();
    wait_word();
    chk("post_rst_word", 32'(dout), 32'(8'hF0));
    chk("post_rst_last", 32'(dout_last), 32'(1));
    wait_idle();

    // randomized traffic against the model
    for (int t = 0; t < 3000; t++) begin
      int r, q;
      din_valid = $urandom_range(0, 9) < 7;
      dout_ready = $urandom_range(0, 9) < 6;
      mode = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r = int'($urandom_range(0, 80)) - 40;
      q = int'($urandom_range(0, 80)) - 40;
      din = ($urandom_range(0, 3) == 0) ? $urandom : {IW'(q), IW'(r)};
      flush = !in_flush && $urandom_range(0, 39) == 0;
      step();
    end
    din_valid = 0;
    flush = 0;
    dout_ready = 1;
    wait_idle();
    flush_pulse();
    wait_idle();
    chk("final_words_drained", 32'(expq.size()), 32'(0));
    chk("final_bits_drained", 32'(bitq.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/qam_demapper_packer.md
Name: qam_demapper_packer

Overview:
- Parametrised hard-decision Gray demapper for square QAM with a runtime-selectable order: QPSK, 16-QAM or 64-QAM.
- Decided bits are packed MSB-first into OW-bit output words.
- Handshaking on both sides is valid/ready with full backpressure; a flush request emits a zero-padded partial word.
- Sits between the equaliser output and the descrambler/deinterleaver in the VLC receive path.

Parameters:
- IW, 16: width of each signed I/Q component.
- SCH, 2: LSBs truncated from each component before decision.
- STEP, 2: decision step (signed, truncated units); boundaries are spaced STEP apart.
- OW, 8: output word width; legal range OW >= 6.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- din  in  2*IW  symbol; [IW-1:0] is re, [2*IW-1:IW] is im, two's complement.
- din_valid  in  1  symbol valid.
- din_ready  out  1  symbol accepted when din_valid and din_ready are both high.
- mode  in  2  order for this symbol: 0 = QPSK, 1 = 16-QAM, 2 = 64-QAM, 3 = reserved.
- flush  in  1  single-cycle request to emit a pending partial word.
- dout  out  OW  packed word.
- dout_valid  out  1  word valid.
- dout_ready  in  1  downstream accept.
- dout_last  out  1  marks the word produced by a flush.
- mode_err  out  1  sticky flag: a symbol was accepted with mode = 3.

Behaviour:
- Reset: when rst_n is low at a clk edge, the following are all cleared: din_ready, dout, dout_valid, dout_last, mode_err, the stage register, the accumulator and its count, and the FSM (FSM returns to RUN). Reset has priority over every other event, including mid-word and mid-flush.
- Truncation: r = re[IW-1:SCH] and i = im[IW-1:SCH], both signed, width IW-SCH. There is no rounding.
- Levels per axis: L = 2, 4 or 8 (for QPSK, 16-QAM, 64-QAM), giving b = 1, 2 or 3 bits per axis.
- Boundaries: (j - L/2)*STEP for j = 1..L-1.
- Region index: k = number of boundaries <= the value, so k is in 0..L-1.
- Axis bits: re bits = gray(k); im bits = gray(L-1-k); gray(x) = x ^ (x >> 1).
- Symbol bits = {re bits, im bits}, so 2b bits per symbol. For 16-QAM this equals the existing 16-QAM demapper map.
- Stage register S holds the symbol bits (up to 6), nbits and a valid flag. It is loaded on an accepted symbol, so mode is sampled per symbol and a mode change between symbols is legal.
- mode = 3: the symbol is consumed and dropped (S not loaded) and mode_err is set. mode_err clears only on reset.
- Packer: accumulator ACC of OW+5 bits with count CNT.
  - S is absorbed when S is valid and CNT < OW. Its bits are appended directly below the existing CNT bits, and CNT increases by nbits.
- Word output: dout_valid = (CNT >= OW) or flush-emit. dout is the top OW bits of ACC.
  - On a dout handshake ACC shifts left by OW and CNT decreases by OW.
  - dout and dout_last are held stable while dout_valid is high and dout_ready is low.
- Same-cycle events:
  - A dout handshake and an S absorb in the same cycle operate on the post-shift count.
  - din_ready = (S empty or S absorbed this cycle) and FSM == RUN.
- Latency: a symbol accepted at edge n is in S after edge n and in ACC after edge n+1. The earliest word containing it has dout_valid high after edge n+1 and is visible in cycle n+2.
- FSM:
  - RUN: flush high moves to DRAIN. din_ready is low outside RUN.
  - DRAIN: waits until S is empty and CNT < OW (full words are still emitted normally). Then CNT == 0 moves to RUN with no output; CNT > 0 moves to EMIT.
  - EMIT: dout_valid = 1, dout = top OW bits of ACC with the bits below CNT zero-padded, dout_last = 1. On handshake CNT = 0 and the FSM returns to RUN.
  - flush outside RUN is ignored.
- dout_last is 0 on every non-flush word.
- Throughput: with dout_ready held high, one symbol is accepted per cycle.

Test Plan:
- IW=16, SCH=2, STEP=2, OW=8, mode=1: symbols (re=-12, im=+12) then (re=+4, im=-4) -> one word dout=0x0F, dout_last=0, first dout_valid two cycles after the second accept.
- mode=2: four symbols (re=+28, im=-28), each giving bits 100100 -> words 0x92, 0x49, 0x24 in order, then CNT=0.
- mode=0: one symbol (re=+4, im=+4), bits 10, then flush pulse -> dout=0x80 with dout_last=1; a flush with CNT=0 produces no word.
- Backpressure:
  - dout_ready=0 and din_valid=1 in mode 1 -> din_ready falls once CNT >= 8 and S is full.
  - dout holds 0x0F stable, and no symbol is lost or duplicated after dout_ready=1.
- Mixed modes:
  - QPSK, then 64-QAM, then reserved mode 3 -> 8 bits packed across the mode change.
  - mode_err=1 with the reserved symbol contributing no bits.
- Reset mid-operation: rst_n=0 for one cycle during EMIT with dout_ready=0 -> next cycle all outputs are 0, FSM is in RUN, and a following symbol packs from CNT=0.
